// File: rtl/guess_pkg.sv
// Shared types and helpers for the 4-LED guessing game auto-player.
package guess_pkg;

  localparam int NUM_LEDS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REACT   = 2'd1,
    PRESS   = 2'd2,
    RELEASE = 2'd3
  } player_state_t;

  // True when exactly one LED is lit.
  function automatic logic is_onehot4(input logic [NUM_LEDS-1:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Deliberate-miss pattern: the neighbouring button, wrapping 3 -> 0.
  function automatic logic [NUM_LEDS-1:0] rotl4(input logic [NUM_LEDS-1:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/guess_autoplayer_if.sv
// Player <-> game link: LED output from the game, button drive from the player,
// and the game's win/lose indications. master = player side, slave = game side.
interface guess_autoplayer_if;
  logic [guess_pkg::NUM_LEDS-1:0] y;
  logic [guess_pkg::NUM_LEDS-1:0] b;
  logic                           win;
  logic                           lose;

  modport master (input y, input win, input lose, output b);
  modport slave  (output y, output win, output lose, input b);
endinterface

// File: rtl/guess_delay_counter.sv
// Loadable down-counter shared by the reaction delay and the button hold time.
// Load wins over decrement; decrement stops at zero.
module guess_delay_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         one_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load, decrement towards zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});
  assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/guess_autoplayer.sv
// Automatic player for the 4-LED guessing game: captures a newly lit LED, waits a
// reaction delay, presses (or deliberately misses), releases and tallies outcomes.
// The button drive lags the PRESS state by one register stage.
module guess_autoplayer
  import guess_pkg::*;
#(
  parameter int REACT_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int MISS_EVERY   = 0,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  guess_autoplayer_if.master gio,
  output logic               busy,
  output logic               attempt_done,
  output logic [SCORE_W-1:0] wins,
  output logic [SCORE_W-1:0] losses
);

  localparam int CNT_MAX = (REACT_CYCLES > HOLD_CYCLES) ? REACT_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam int MI_W    = (MISS_EVERY < 2) ? 1 : $clog2(MISS_EVERY);

  localparam logic [CNT_W-1:0] REACT_LOAD = CNT_W'(REACT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES);
  localparam logic [MI_W-1:0]  MISS_LAST  = (MISS_EVERY > 0) ? MI_W'(MISS_EVERY - 1) : {MI_W{1'b0}};

  player_state_t         state_q, state_d;
  logic [NUM_LEDS-1:0]   target_q, target_d;
  logic [NUM_LEDS-1:0]   last_y_q, last_y_d;
  logic [NUM_LEDS-1:0]   pat_q, pat_d;
  logic [NUM_LEDS-1:0]   b_q, b_d;
  logic [MI_W-1:0]       miss_idx_q, miss_idx_d;
  logic                  recorded_q, recorded_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [SCORE_W-1:0]    wins_q, wins_d;
  logic [SCORE_W-1:0]    losses_q, losses_d;

  logic                  cnt_load_s;
  logic [CNT_W-1:0]      cnt_val_s;
  logic                  cnt_dec_s;
  logic                  cnt_zero_s;
  logic                  cnt_one_s;
  logic                  go_press_s;
  logic                  outcome_ok_s;
  logic                  miss_due_s;
  logic [NUM_LEDS-1:0]   press_tgt_s;

  guess_delay_counter #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s),
    .one_o      (cnt_one_s)
  );

  assign miss_due_s = (MISS_EVERY > 0) && (miss_idx_q == MISS_LAST);

  // Next-state, counter control, outcome tally and registered-output decode.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    last_y_d     = last_y_q;
    pat_d        = pat_q;
    miss_idx_d   = miss_idx_q;
    recorded_d   = recorded_q;
    wins_d       = wins_q;
    losses_d     = losses_q;
    done_d       = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_val_s    = {CNT_W{1'b0}};
    cnt_dec_s    = 1'b0;
    go_press_s   = 1'b0;
    outcome_ok_s = 1'b0;
    press_tgt_s  = target_q;

    case (state_q)
      IDLE: begin
        if (en && is_onehot4(gio.y) && (gio.y != last_y_q)) begin
          target_d    = gio.y;
          press_tgt_s = gio.y;
          if (REACT_CYCLES == 0) begin
            go_press_s = 1'b1;
          end else begin
            state_d    = REACT;
            cnt_load_s = 1'b1;
            cnt_val_s  = REACT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REACT: begin
        // Abort leaves last_y untouched so a new LED is picked up right away.
        if (!en || (gio.y != target_q)) begin
          state_d = IDLE;
        end else begin
          cnt_dec_s = 1'b1;
          if (cnt_one_s || cnt_zero_s) begin
            go_press_s = 1'b1;
          end else begin
            state_d = REACT;
          end
        end
      end
      PRESS: begin
        outcome_ok_s = 1'b1;
        cnt_dec_s    = 1'b1;
        if (cnt_one_s || cnt_zero_s) begin
          state_d = RELEASE;
        end else begin
          state_d = PRESS;
        end
      end
      RELEASE: begin
        outcome_ok_s = 1'b1;
        if (!(gio.win || gio.lose)) begin
          state_d  = IDLE;
          last_y_d = target_q;
          done_d   = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entry into PRESS: choose the button pattern and advance the attempt index.
    if (go_press_s) begin
      state_d    = PRESS;
      cnt_load_s = 1'b1;
      cnt_val_s  = HOLD_LOAD;
      recorded_d = 1'b0;
      pat_d      = miss_due_s ? rotl4(press_tgt_s) : press_tgt_s;
      if (MISS_EVERY > 0) begin
        miss_idx_d = miss_due_s ? {MI_W{1'b0}} : (miss_idx_q + MI_W'(1));
      end else begin
        miss_idx_d = {MI_W{1'b0}};
      end
    end else begin
      pat_d = pat_q;
    end

    // Only the first outcome of an attempt counts; lose dominates win.
    if (outcome_ok_s && !recorded_q && (gio.win || gio.lose)) begin
      recorded_d = 1'b1;
      if (gio.lose) begin
        losses_d = (losses_q != {SCORE_W{1'b1}}) ? (losses_q + SCORE_W'(1)) : losses_q;
      end else begin
        wins_d = (wins_q != {SCORE_W{1'b1}}) ? (wins_q + SCORE_W'(1)) : wins_q;
      end
    end else begin
      recorded_d = recorded_d;
    end

    b_d    = (state_q == PRESS) ? pat_q : 4'b0000;
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      target_q   <= 4'b0000;
      last_y_q   <= 4'b0000;
      pat_q      <= 4'b0000;
      b_q        <= 4'b0000;
      miss_idx_q <= {MI_W{1'b0}};
      recorded_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wins_q     <= {SCORE_W{1'b0}};
      losses_q   <= {SCORE_W{1'b0}};
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      last_y_q   <= last_y_d;
      pat_q      <= pat_d;
      b_q        <= b_d;
      miss_idx_q <= miss_idx_d;
      recorded_q <= recorded_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wins_q     <= wins_d;
      losses_q   <= losses_d;
    end
  end

  assign gio.b        = b_q;
  assign busy         = busy_q;
  assign attempt_done = done_q;
  assign wins         = wins_q;
  assign losses       = losses_q;

endmodule
